// File: rtl/hook_pkg.sv
// hook_pkg: shared types and constants for the fishing-line sequencer.
//   state_t      : sequencer phase
//   MODE_*       : renderer mode codes driven on hook_ctrl.mode
//   DEF_SURFACE  : default top hook row (stowed position)
//   DEF_BOTTOM   : default deepest hook row
//   mode_of()    : renderer mode for a given phase / bait / fish combination
package hook_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SINK,
    ST_FISH,
    ST_BITE,
    ST_REEL
  } state_t;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_HOOK = 2'd1;
  localparam logic [1:0] MODE_BAIT = 2'd2;
  localparam logic [1:0] MODE_FISH = 2'd3;

  localparam int DEF_SURFACE = 62;
  localparam int DEF_BOTTOM  = 460;

  function automatic logic [1:0] mode_of(input state_t st, input logic bait, input logic fish);
    logic [1:0] m;
    m = bait ? MODE_BAIT : MODE_HOOK;
    case (st)
      ST_IDLE: m = MODE_NONE;
      ST_BITE: m = MODE_FISH;
      ST_REEL: if (fish) m = MODE_FISH;
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hook_stepper.sv
// hook_stepper: moves a 10-bit position toward a target by at most `step`,
// landing exactly on the target when it is closer than one step.
// Differences are only formed after the compare, so nothing wraps.
//   pos  in 10 : current position
//   tgt  in 10 : target position
//   step in 10 : maximum move
//   nxt  out 10: next position
module hook_stepper (
  input  logic [9:0] pos,
  input  logic [9:0] tgt,
  input  logic [9:0] step,
  output logic [9:0] nxt
);

  always_comb begin
    nxt = pos;
    if (tgt > pos)
      nxt = ((tgt - pos) > step) ? pos + step : tgt;
    else if (tgt < pos)
      nxt = ((pos - tgt) > step) ? pos - step : tgt;
  end

endmodule

// File: rtl/hook_ctrl.sv
// hook_ctrl: fishing-line sequencer. Steps IDLE -> SINK -> FISH -> BITE -> REEL,
// owns the hook row and renderer mode, and pulses catch/escape events.
//   clk, rst_n    : clock, async active-low reset
//   frame_tick    : one pulse per frame; all hook movement happens on it
//   cast          : start a cast (IDLE only)
//   reel          : start reeling (FISH / BITE)
//   bait_load     : attach bait (IDLE only)
//   bite          : fish touches the hook
//   target_v[9:0] : mouse row, clamped to [SURFACE, BOTTOM]
//   mode[1:0]     : renderer mode (none / hook / hook+bait / fish)
//   hook_v[9:0]   : current hook top row
//   bait_loaded   : bait attached
//   catch_o       : one-cycle pulse, fish landed
//   escape_o      : one-cycle pulse, fish lost
module hook_ctrl
  import hook_pkg::*;
#(
  parameter int SURFACE      = DEF_SURFACE,
  parameter int BOTTOM       = DEF_BOTTOM,
  parameter int SINK_STEP    = 2,
  parameter int REEL_STEP    = 4,
  parameter int BITE_TIMEOUT = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       cast,
  input  logic       reel,
  input  logic       bait_load,
  input  logic       bite,
  input  logic [9:0] target_v,
  output logic [1:0] mode,
  output logic [9:0] hook_v,
  output logic       bait_loaded,
  output logic       catch_o,
  output logic       escape_o
);

  localparam int TW = $clog2(BITE_TIMEOUT + 1);

  localparam logic [9:0]    SURF    = 10'(SURFACE);
  localparam logic [9:0]    BOT     = 10'(BOTTOM);
  localparam logic [9:0]    SSTEP   = 10'(SINK_STEP);
  localparam logic [9:0]    RSTEP   = 10'(REEL_STEP);
  localparam logic [TW-1:0] TO_LAST = TW'(BITE_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(BITE_TIMEOUT);

  state_t        state, state_d;
  logic          fish, fish_d;
  logic [TW-1:0] timer, timer_d;
  logic [9:0]    hook_d;
  logic          bait_d, catch_d, escape_d;
  logic [1:0]    mode_d;

  logic [9:0] tgt, follow_tgt, follow_nxt, reel_nxt;
  logic       timeout_hit;

  // Clamp the mouse row into the legal hook range.
  always_comb begin
    tgt = target_v;
    if (target_v < SURF)     tgt = SURF;
    else if (target_v > BOT) tgt = BOT;
  end

  // Sinking only ever moves down: a target above the hook pins it in place.
  assign follow_tgt = (state == ST_SINK && tgt < hook_v) ? hook_v : tgt;

  hook_stepper u_follow (
    .pos  (hook_v),
    .tgt  (follow_tgt),
    .step (SSTEP),
    .nxt  (follow_nxt)
  );

  hook_stepper u_reel (
    .pos  (hook_v),
    .tgt  (SURF),
    .step (RSTEP),
    .nxt  (reel_nxt)
  );

  // The tick that takes the timer to BITE_TIMEOUT is the escaping tick.
  assign timeout_hit = frame_tick && (timer == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (cast) state_d = ST_SINK;
      ST_SINK: if (frame_tick && follow_nxt >= tgt) state_d = ST_FISH;
      ST_FISH: begin
        if (reel)                     state_d = ST_REEL;
        else if (bite && bait_loaded) state_d = ST_BITE;
      end
      ST_BITE: begin
        if (reel)             state_d = ST_REEL;
        else if (timeout_hit) state_d = ST_FISH;
      end
      ST_REEL: if (frame_tick && reel_nxt == SURF) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and side state. Movement on a tick
  // follows the current state's rule even if a control pulse changes state
  // on the same edge.
  always_comb begin
    hook_d   = hook_v;
    bait_d   = bait_loaded;
    fish_d   = fish;
    timer_d  = timer;
    catch_d  = 1'b0;
    escape_d = 1'b0;

    if (frame_tick) begin
      case (state)
        ST_SINK, ST_FISH: hook_d = follow_nxt;
        ST_REEL:          hook_d = reel_nxt;
        default:          ;
      endcase
    end

    case (state)
      ST_IDLE: if (bait_load) bait_d = 1'b1;
      ST_FISH: begin
        if (reel)                     fish_d  = 1'b0;
        else if (bite && bait_loaded) timer_d = '0;
      end
      ST_BITE: begin
        if (reel) fish_d = 1'b1;
        else if (frame_tick) begin
          if (timer != TO_MAX) timer_d = timer + TW'(1);
          if (timeout_hit) begin
            escape_d = 1'b1;
            bait_d   = 1'b0;
          end
        end
      end
      ST_REEL: begin
        if (state_d == ST_IDLE && fish) begin
          catch_d = 1'b1;
          bait_d  = 1'b0;
          fish_d  = 1'b0;
        end
      end
      default: ;
    endcase

    mode_d = mode_of(state_d, bait_d, fish_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hook_v      <= SURF;
      mode        <= MODE_NONE;
      bait_loaded <= 1'b0;
      fish        <= 1'b0;
      timer       <= '0;
      catch_o     <= 1'b0;
      escape_o    <= 1'b0;
    end else begin
      hook_v      <= hook_d;
      mode        <= mode_d;
      bait_loaded <= bait_d;
      fish        <= fish_d;
      timer       <= timer_d;
      catch_o     <= catch_d;
      escape_o    <= escape_d;
    end
  end

endmodule

// File: tb/tb_hook_ctrl.sv
// tb_hook_ctrl: directed scenarios followed by random pulses, every cycle
// compared against a phase-level reference model of the hook sequencer.
module tb_hook_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, cast = 1'b0, reel = 1'b0, bait_load = 1'b0, bite = 1'b0;
  logic [9:0] target_v = 10'd62;
  logic [1:0] mode;
  logic [9:0] hook_v;
  logic       bait_loaded, catch_o, escape_o;

  int vectors = 0, miscompares = 0;
  int catch_cnt = 0, escape_cnt = 0;
  int c0, e0;

  localparam int P_IDLE = 0, P_SINK = 1, P_FISH = 2, P_BITE = 3, P_REEL = 4;
  int m_ph, m_pos, m_timer;
  bit m_bait, m_fish, m_catch, m_escape;

  hook_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .cast        (cast),
    .reel        (reel),
    .bait_load   (bait_load),
    .bite        (bite),
    .target_v    (target_v),
    .mode        (mode),
    .hook_v      (hook_v),
    .bait_loaded (bait_loaded),
    .catch_o     (catch_o),
    .escape_o    (escape_o)
  );

  always #5 clk = ~clk;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clampt(input int v);
    return (v < 62) ? 62 : (v > 460) ? 460 : v;
  endfunction

  function automatic int m_mode();
    if (m_ph == P_IDLE) return 0;
    if (m_ph == P_BITE || (m_ph == P_REEL && m_fish)) return 3;
    return m_bait ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_pos = 62; m_timer = 0;
    m_bait = 0; m_fish = 0; m_catch = 0; m_escape = 0;
  endtask

  // One clock edge of the phase-level behaviour, using the inputs sampled at it.
  task automatic model_step();
    int t;
    t = clampt(int'(target_v));
    m_catch = 0; m_escape = 0;
    case (m_ph)
      P_IDLE: begin
        if (bait_load) m_bait = 1;
        if (cast) m_ph = P_SINK;
      end
      P_SINK: if (frame_tick) begin
        if (t > m_pos) m_pos += min2(2, t - m_pos);
        if (m_pos >= t) m_ph = P_FISH;
      end
      P_FISH: begin
        if (frame_tick) begin
          if (t > m_pos) m_pos += min2(2, t - m_pos);
          else           m_pos -= min2(2, m_pos - t);
        end
        if (reel) begin m_ph = P_REEL; m_fish = 0; end
        else if (bite && m_bait) begin m_ph = P_BITE; m_timer = 0; end
      end
      P_BITE: begin
        if (reel) begin m_ph = P_REEL; m_fish = 1; end
        else if (frame_tick) begin
          m_timer++;
          if (m_timer == 120) begin m_ph = P_FISH; m_escape = 1; m_bait = 0; end
        end
      end
      P_REEL: if (frame_tick) begin
        m_pos -= min2(4, m_pos - 62);
        if (m_pos == 62) begin
          m_ph = P_IDLE;
          if (m_fish) begin m_catch = 1; m_bait = 0; m_fish = 0; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("mode",   {8'b0, mode},        10'(m_mode()));
    chk("hook_v", hook_v,              10'(m_pos));
    chk("bait",   {9'b0, bait_loaded}, {9'b0, m_bait});
    chk("catch",  {9'b0, catch_o},     {9'b0, m_catch});
    chk("escape", {9'b0, escape_o},    {9'b0, m_escape});
  endtask

  // Inputs are set before the call; one edge elapses, then outputs are
  // checked on the falling edge and pulse inputs are dropped.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    if (catch_o)  catch_cnt++;
    if (escape_o) escape_cnt++;
    check_model();
    frame_tick = 0; cast = 0; reel = 0; bait_load = 0; bite = 0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1;
      cycle();
      cycle();
      cycle();
    end
  endtask

  initial begin
    model_reset();
    // reset state
    rst_n = 0;
    cycle(); cycle();
    chk("rst_hook", hook_v, 10'd62);
    chk("rst_mode", {8'b0, mode}, 10'd0);
    chk("rst_bait", {9'b0, bait_loaded}, 10'd0);
    rst_n = 1;
    cycle();

    // bait, cast to 100: 19 ticks of sinking
    bait_load = 1; cycle();
    chk("bait_set", {9'b0, bait_loaded}, 10'd1);
    target_v = 10'd100; cast = 1; cycle();
    chk("cast_mode", {8'b0, mode}, 10'd2);
    frames(18);
    chk("sink_18", hook_v, 10'd98);
    frames(1);
    chk("sink_19", hook_v, 10'd100);
    chk("fish_mode", {8'b0, mode}, 10'd2);

    // follow upward, floor at SURFACE
    target_v = 10'd30; frames(19);
    chk("follow_up", hook_v, 10'd62);
    frames(3);
    chk("surface_floor", hook_v, 10'd62);

    // bite with bait, reel after 10 ticks, catch
    target_v = 10'd100; frames(19);
    chk("back_100", hook_v, 10'd100);
    bite = 1; cycle();
    chk("bite_mode", {8'b0, mode}, 10'd3);
    frames(10);
    chk("bite_frozen", hook_v, 10'd100);
    chk("bite_mode10", {8'b0, mode}, 10'd3);
    reel = 1; cycle();
    c0 = catch_cnt;
    frames(9);
    chk("reel_9", hook_v, 10'd64);
    chk("reel_mode", {8'b0, mode}, 10'd3);
    frames(1);
    chk("reel_10", hook_v, 10'd62);
    chk("catch_once", 10'(catch_cnt - c0), 10'd1);
    chk("catch_bait", {9'b0, bait_loaded}, 10'd0);
    chk("catch_idle", {8'b0, mode}, 10'd0);

    // bite without bait ignored
    cast = 1; cycle();
    chk("nobait_mode", {8'b0, mode}, 10'd1);
    frames(19);
    bite = 1; cycle();
    chk("nobait_bite", {8'b0, mode}, 10'd1);
    frames(2);
    chk("nobait_hook", hook_v, 10'd100);

    // escape after 120 ticks
    reel = 1; cycle(); frames(10);
    bait_load = 1; cycle();
    cast = 1; cycle();
    frames(19);
    bite = 1; cycle();
    e0 = escape_cnt;
    frames(119);
    chk("no_early_escape", 10'(escape_cnt - e0), 10'd0);
    chk("bite_119_mode", {8'b0, mode}, 10'd3);
    frame_tick = 1; cycle();
    chk("escape_pulse", {9'b0, escape_o}, 10'd1);
    chk("escape_mode", {8'b0, mode}, 10'd1);
    chk("escape_bait", {9'b0, bait_loaded}, 10'd0);
    cycle(); cycle();
    chk("escape_once", 10'(escape_cnt - e0), 10'd1);

    // reel beats bite in FISH
    reel = 1; cycle(); frames(10);
    bait_load = 1; cycle();
    cast = 1; cycle();
    frames(19);
    reel = 1; bite = 1; cycle();
    chk("reel_over_bite", {8'b0, mode}, 10'd2);
    c0 = catch_cnt;
    frames(10);
    chk("no_catch", 10'(catch_cnt - c0), 10'd0);
    chk("no_catch_idle", {8'b0, mode}, 10'd0);
    chk("no_catch_bait", {9'b0, bait_loaded}, 10'd1);

    // reset during REEL with a fish on
    cast = 1; cycle();
    frames(19);
    bite = 1; cycle();
    reel = 1; cycle();
    chk("reel_fish_mode", {8'b0, mode}, 10'd3);
    frames(3);
    c0 = catch_cnt;
    rst_n = 0;
    #1;
    model_reset();
    chk("mid_rst_hook", hook_v, 10'd62);
    chk("mid_rst_mode", {8'b0, mode}, 10'd0);
    chk("mid_rst_bait", {9'b0, bait_loaded}, 10'd0);
    chk("mid_rst_catch", {9'b0, catch_o}, 10'd0);
    @(negedge clk);
    cycle();
    rst_n = 1;
    frames(12);
    chk("rst_no_catch", 10'(catch_cnt - c0), 10'd0);
    chk("rst_idle_mode", {8'b0, mode}, 10'd0);

    // random pulses against the model
    for (int i = 0; i < 2500; i++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      cast       = ($urandom_range(0, 15) == 0);
      reel       = ($urandom_range(0, 19) == 0);
      bait_load  = ($urandom_range(0, 11) == 0);
      bite       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) target_v = 10'($urandom_range(0, 1023));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hook_ctrl.md
# hook_ctrl

Sequencer for the fishing line. It owns the hook's vertical position and the renderer mode, and steps through the cast, sink, fish, bite and reel phases once per video frame. Its `mode` and `hook_v` outputs drive the hook/bait sprite renderer directly, in place of raw mouse data. Its `catch_o` and `escape_o` pulses feed the score and inventory logic.

## Interface
Parameters:
- `SURFACE`, 62: top hook row; hook rests here when stowed.
- `BOTTOM`, 460: deepest allowed hook row.
- `SINK_STEP`, 2: maximum rows moved per frame while sinking or following the mouse.
- `REEL_STEP`, 4: rows moved up per frame while reeling.
- `BITE_TIMEOUT`, 120: frames a hooked fish stays on before escaping.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame (vsync edge).
- `cast` in 1: one-cycle pulse, cast request.
- `reel` in 1: one-cycle pulse, reel request.
- `bait_load` in 1: one-cycle pulse, attach bait.
- `bite` in 1: one-cycle pulse, a fish touches the hook.
- `target_v` in 10: mouse row.
- `mode` out 2: 0 = none, 1 = hook only, 2 = hook + bait, 3 = fish on hook.
- `hook_v` out 10: current hook top row.
- `bait_loaded` out 1: bait currently attached.
- `catch_o` out 1: one-cycle pulse, fish landed.
- `escape_o` out 1: one-cycle pulse, fish lost.

## Operation
- States are IDLE, SINK, FISH, BITE and REEL.
- Reset values: state IDLE, `hook_v` = SURFACE, `mode` = 0, `bait_loaded` = 0, `catch_o` = 0, `escape_o` = 0, bite timer 0, fish flag 0.
- Clamped target `tgt` = min(max(`target_v`, SURFACE), BOTTOM).
- **IDLE**
  - `mode` = 0.
  - `bait_load` sets `bait_loaded`.
  - `cast` → SINK.
- **SINK**
  - On each `frame_tick`, `hook_v` += min(SINK_STEP, `tgt` − `hook_v`).
  - When `hook_v` ≥ `tgt` → FISH.
  - If `tgt` ≤ `hook_v` on entry, go to FISH on the first tick.
- **FISH**
  - On each `frame_tick`, `hook_v` moves toward `tgt` by at most SINK_STEP, in either direction, snapping to `tgt` when closer than one step.
  - `reel` → REEL with fish flag = 0.
  - `bite` with `bait_loaded` → BITE; bite timer cleared.
  - `bite` without bait is ignored.
- **BITE**
  - `hook_v` is frozen.
  - The bite timer increments on each `frame_tick`.
  - `reel` → REEL with fish flag = 1.
  - Timer reaching BITE_TIMEOUT → FISH, `escape_o` pulses, `bait_loaded` cleared.
- **REEL**
  - On each `frame_tick`, `hook_v` −= min(REEL_STEP, `hook_v` − SURFACE).
  - When `hook_v` = SURFACE → IDLE.
  - If the fish flag is set: `catch_o` pulses, `bait_loaded` cleared, fish flag cleared.
- `mode` per state:
  - IDLE: 0.
  - SINK, FISH, and REEL with no fish: 2 if `bait_loaded`, else 1.
  - BITE, and REEL with fish flag set: 3.
- Priority and ignored inputs:
  - `cast` is ignored outside IDLE.
  - `bait_load` is ignored outside IDLE.
  - `reel` is ignored in IDLE and SINK.
  - In FISH, `reel` beats `bite` in the same cycle.
  - In BITE, `reel` beats timeout in the same cycle; no escape occurs.
- Arithmetic: all positions are 10-bit unsigned. Differences are computed only after a compare, so there is no wrap. `hook_v` never leaves [SURFACE, BOTTOM].
- A reset asserted mid-operation returns immediately to the reset values. A pending catch is discarded.

## Timing
- All outputs are registered.
- A control pulse sampled at edge n changes state and `mode` at edge n+1.
- Position updates only on edges where `frame_tick` = 1. Control pulses act on any cycle.
- A control pulse coincident with `frame_tick` transitions state; the movement for that tick applies the new state's rule from the next tick onward.
- `catch_o` and `escape_o` are high for exactly one cycle, coincident with the first cycle in the destination state.
- Bite timer width is ceil(log2(BITE_TIMEOUT + 1)) bits, saturating.

## Structure
- Package `hook_pkg` holds:
  - the state enum;
  - mode constants MODE_NONE, MODE_HOOK, MODE_BAIT, MODE_FISH;
  - default SURFACE and BOTTOM.
- Sub-module `hook_stepper` (combinational): takes current position, target and step, and returns the saturating next position. It is used by SINK/FISH and by REEL (target = SURFACE).
- Expected size is about 200 lines including the FSM and timer.

## Test plan
- Reset, `bait_load`, then `cast` with `target_v` = 100 and SINK_STEP = 2:
  - SINK for 19 ticks, `hook_v` goes 62 → 100, then FISH with `mode` = 2.
- In FISH at 100, `target_v` = 30:
  - `hook_v` descends by 2 per tick to 62 and stops; it never goes below SURFACE.
- `bite` at row 100 with bait, then `reel` 10 ticks later:
  - `mode` = 3 throughout.
  - After 10 reel ticks `hook_v` = 62.
  - `catch_o` pulses once; `bait_loaded` = 0; state IDLE.
- `bite` with no bait:
  - No state change; `mode` stays 1.
- `bite` with bait and no reel for 120 ticks:
  - `escape_o` pulses on tick 120; state FISH, `mode` = 1.
- `reel` and `bite` in the same cycle in FISH:
  - REEL with `mode` = 2; no catch at the surface.
- `rst_n` low during REEL with the fish flag set:
  - All outputs return to their reset values; no `catch_o`.
